// File: rtl/isa_pkg.sv
// ISA constants shared by the ID-stage decoder and its micro-op ROM:
// opcodes, ALU command codes, branch types and macro-op lengths.
package isa_pkg;

    localparam logic [5:0] OP_NOP  = 6'b000000;
    localparam logic [5:0] OP_ADD  = 6'b000001;
    localparam logic [5:0] OP_SUB  = 6'b000011;
    localparam logic [5:0] OP_AND  = 6'b000101;
    localparam logic [5:0] OP_OR   = 6'b000110;
    localparam logic [5:0] OP_NOR  = 6'b000111;
    localparam logic [5:0] OP_XOR  = 6'b001000;
    localparam logic [5:0] OP_SLA  = 6'b001001;
    localparam logic [5:0] OP_SLL  = 6'b001010;
    localparam logic [5:0] OP_SRA  = 6'b001011;
    localparam logic [5:0] OP_SRL  = 6'b001100;
    localparam logic [5:0] OP_ADDI = 6'b100000;
    localparam logic [5:0] OP_SUBI = 6'b100001;
    localparam logic [5:0] OP_LD   = 6'b100100;
    localparam logic [5:0] OP_ST   = 6'b100101;
    localparam logic [5:0] OP_BEZ  = 6'b101000;
    localparam logic [5:0] OP_BNE  = 6'b101001;
    localparam logic [5:0] OP_JMP  = 6'b101010;
    localparam logic [5:0] OP_ROT  = 6'b111110;
    localparam logic [5:0] OP_SWP  = 6'b111111;

    localparam logic [3:0] CMD_ADD  = 4'b0000;
    localparam logic [3:0] CMD_SUB  = 4'b0010;
    localparam logic [3:0] CMD_AND  = 4'b0100;
    localparam logic [3:0] CMD_OR   = 4'b0101;
    localparam logic [3:0] CMD_NOR  = 4'b0110;
    localparam logic [3:0] CMD_XOR  = 4'b0111;
    localparam logic [3:0] CMD_SHL  = 4'b1000;
    localparam logic [3:0] CMD_SRA  = 4'b1001;
    localparam logic [3:0] CMD_SRL  = 4'b1010;
    localparam logic [3:0] CMD_UOP0 = 4'b1100;
    localparam logic [3:0] CMD_UOP1 = 4'b1101;
    localparam logic [3:0] CMD_UOP2 = 4'b1110;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEZ  = 2'b01;
    localparam logic [1:0] BR_BNE  = 2'b10;
    localparam logic [1:0] BR_JMP  = 2'b11;

    localparam int unsigned SWP_UOPS = 2;
    localparam int unsigned ROT_UOPS = 3;

    typedef enum logic {
        ST_IDLE,
        ST_SEQ
    } seq_state_e;

    typedef struct packed {
        logic [3:0] cmd;
        logic       mem_r;
        logic       mem_w;
        logic       wb;
        logic       imm;
        logic [1:0] br;
        logic       single_src;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    function automatic ctrl_t mk_ctrl(input logic [3:0] cmd, input logic mem_r,
                                      input logic mem_w, input logic wb, input logic imm,
                                      input logic [1:0] br, input logic single_src);
        ctrl_t c;
        c.cmd        = cmd;
        c.mem_r      = mem_r;
        c.mem_w      = mem_w;
        c.wb         = wb;
        c.imm        = imm;
        c.br         = br;
        c.single_src = single_src;
        return c;
    endfunction

endpackage

// File: rtl/uop_rom.sv
// Micro-op ROM: maps (macro opcode, micro-op index) to the ALU command,
// write-back enable, datapath mux select and last-micro-op flag.
module uop_rom
    import isa_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int CMD_W    = 4,
    parameter int SEL_W    = 3
) (
    input  logic [OPCODE_W-1:0] seq_op_i,
    input  logic [SEL_W-1:0]    idx_i,
    output logic                is_macro_o,
    output logic [CMD_W-1:0]    exec_cmd_o,
    output logic                wb_en_o,
    output logic [SEL_W-1:0]    uop_sel_o,
    output logic                last_o
);

    int unsigned n_uops;

    always_comb begin
        n_uops = 0;
        if (seq_op_i == OPCODE_W'(OP_SWP)) begin
            n_uops = SWP_UOPS;
        end else if (seq_op_i == OPCODE_W'(OP_ROT)) begin
            n_uops = ROT_UOPS;
        end
    end

    // Micro-op commands are consecutive from CMD_UOP0, so the index offsets the base code.
    always_comb begin
        is_macro_o = (n_uops != 0);
        exec_cmd_o = '0;
        wb_en_o    = 1'b0;
        uop_sel_o  = '0;
        last_o     = 1'b0;
        if (is_macro_o && (32'(idx_i) < n_uops)) begin
            exec_cmd_o = CMD_W'(32'(CMD_UOP0) + 32'(idx_i));
            wb_en_o    = 1'b1;
            uop_sel_o  = idx_i + SEL_W'(1);
            last_o     = (32'(idx_i) == n_uops - 1);
        end
    end

endmodule

// File: rtl/control_unit_seq.sv
// ID-stage decoder: combinational single-cycle decode plus a sequencer FSM
// that expands SWP/ROT macro-ops into micro-ops while freezing IF/ID.
module control_unit_seq
    import isa_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int CMD_W    = 4,
    parameter int MAX_UOPS = 4,
    parameter int SEL_W    = $clog2(MAX_UOPS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                instr_valid,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                stall,
    input  logic                flush,
    output logic [CMD_W-1:0]    exec_cmd,
    output logic                mem_r_en,
    output logic                mem_w_en,
    output logic                wb_en,
    output logic                is_imm,
    output logic [1:0]          branch_type,
    output logic                single_src,
    output logic [SEL_W-1:0]    uop_sel,
    output logic                freeze,
    output logic                busy,
    output logic                illegal_op
);

    if (MAX_UOPS < 3) begin : g_max_uops_check
        $error("control_unit_seq: MAX_UOPS must be >= 3 to hold ROT");
    end

    seq_state_e          state_q, state_d;
    logic [SEL_W-1:0]    idx_q, idx_d;
    logic [OPCODE_W-1:0] seq_op_q, seq_op_d;

    ctrl_t               dec;
    logic                dec_hit;
    logic                in_seq;
    logic [OPCODE_W-1:0] rom_op;
    logic [SEL_W-1:0]    rom_idx;
    logic                rom_macro, rom_wb, rom_last;
    logic [CMD_W-1:0]    rom_cmd;
    logic [SEL_W-1:0]    rom_sel;
    logic                use_dec, use_rom, accept;

    assign in_seq  = (state_q == ST_SEQ);
    assign rom_op  = in_seq ? seq_op_q : opcode;
    assign rom_idx = in_seq ? idx_q : '0;
    assign accept  = instr_valid && !stall && !flush;

    uop_rom #(
        .OPCODE_W (OPCODE_W),
        .CMD_W    (CMD_W),
        .SEL_W    (SEL_W)
    ) u_uop_rom (
        .seq_op_i   (rom_op),
        .idx_i      (rom_idx),
        .is_macro_o (rom_macro),
        .exec_cmd_o (rom_cmd),
        .wb_en_o    (rom_wb),
        .uop_sel_o  (rom_sel),
        .last_o     (rom_last)
    );

    always_comb begin
        dec     = CTRL_BUBBLE;
        dec_hit = 1'b1;
        case (opcode)
            OPCODE_W'(OP_NOP):  dec = CTRL_BUBBLE;
            OPCODE_W'(OP_ADD):  dec = mk_ctrl(CMD_ADD, 1'b0, 1'b0, 1'b1, 1'b0, BR_NONE, 1'b0);
            OPCODE_W'(OP_SUB):  dec = mk_ctrl(CMD_SUB, 1'b0, 1'b0, 1'b1, 1'b0, BR_NONE, 1'b0);
            OPCODE_W'(OP_AND):  dec = mk_ctrl(CMD_AND, 1'b0, 1'b0, 1'b1, 1'b0, BR_NONE, 1'b0);
            OPCODE_W'(OP_OR):   dec = mk_ctrl(CMD_OR,  1'b0, 1'b0, 1'b1, 1'b0, BR_NONE, 1'b0);
            OPCODE_W'(OP_NOR):  dec = mk_ctrl(CMD_NOR, 1'b0, 1'b0, 1'b1, 1'b0, BR_NONE, 1'b0);
            OPCODE_W'(OP_XOR):  dec = mk_ctrl(CMD_XOR, 1'b0, 1'b0, 1'b1, 1'b0, BR_NONE, 1'b0);
            OPCODE_W'(OP_SLA),
            OPCODE_W'(OP_SLL):  dec = mk_ctrl(CMD_SHL, 1'b0, 1'b0, 1'b1, 1'b0, BR_NONE, 1'b0);
            OPCODE_W'(OP_SRA):  dec = mk_ctrl(CMD_SRA, 1'b0, 1'b0, 1'b1, 1'b0, BR_NONE, 1'b0);
            OPCODE_W'(OP_SRL):  dec = mk_ctrl(CMD_SRL, 1'b0, 1'b0, 1'b1, 1'b0, BR_NONE, 1'b0);
            OPCODE_W'(OP_ADDI): dec = mk_ctrl(CMD_ADD, 1'b0, 1'b0, 1'b1, 1'b1, BR_NONE, 1'b1);
            OPCODE_W'(OP_SUBI): dec = mk_ctrl(CMD_SUB, 1'b0, 1'b0, 1'b1, 1'b1, BR_NONE, 1'b1);
            OPCODE_W'(OP_LD):   dec = mk_ctrl(CMD_ADD, 1'b1, 1'b0, 1'b1, 1'b1, BR_NONE, 1'b1);
            OPCODE_W'(OP_ST):   dec = mk_ctrl(CMD_ADD, 1'b0, 1'b1, 1'b0, 1'b1, BR_NONE, 1'b0);
            OPCODE_W'(OP_BEZ):  dec = mk_ctrl(CMD_ADD, 1'b0, 1'b0, 1'b0, 1'b1, BR_BEZ,  1'b1);
            OPCODE_W'(OP_BNE):  dec = mk_ctrl(CMD_ADD, 1'b0, 1'b0, 1'b0, 1'b1, BR_BNE,  1'b0);
            OPCODE_W'(OP_JMP):  dec = mk_ctrl(CMD_ADD, 1'b0, 1'b0, 1'b0, 1'b1, BR_JMP,  1'b1);
            default:            dec_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            seq_op_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            seq_op_q <= seq_op_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        seq_op_d = seq_op_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept && !dec_hit && rom_macro && !rom_last) begin
                    state_d  = ST_SEQ;
                    idx_d    = SEL_W'(1);
                    seq_op_d = opcode;
                end
            end
            ST_SEQ: begin
                if (flush || (!stall && rom_last)) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else if (!stall) begin
                    idx_d = idx_q + SEL_W'(1);
                end
            end
        endcase
    end

    // Every output is forced to zero while rst_n is low, independent of the inputs.
    always_comb begin
        use_dec    = 1'b0;
        use_rom    = 1'b0;
        freeze     = 1'b0;
        illegal_op = 1'b0;
        busy       = rst_n && in_seq;
        if (rst_n) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (dec_hit) begin
                            use_dec = 1'b1;
                        end else if (rom_macro) begin
                            use_rom = 1'b1;
                            freeze  = !rom_last;
                        end else begin
                            illegal_op = 1'b1;
                        end
                    end
                end
                ST_SEQ: begin
                    if (!flush) begin
                        if (stall) begin
                            freeze = 1'b1;
                        end else begin
                            use_rom = 1'b1;
                            freeze  = !rom_last;
                        end
                    end
                end
            endcase
        end
        exec_cmd    = use_dec ? CMD_W'(dec.cmd) : (use_rom ? rom_cmd : '0);
        mem_r_en    = use_dec && dec.mem_r;
        mem_w_en    = use_dec && dec.mem_w;
        wb_en       = (use_dec && dec.wb) || (use_rom && rom_wb);
        is_imm      = use_dec && dec.imm;
        branch_type = use_dec ? dec.br : BR_NONE;
        single_src  = use_dec && dec.single_src;
        uop_sel     = use_rom ? rom_sel : '0;
    end

endmodule

// File: tb/tb_control_unit_seq.sv
// Directed-vector bench for control_unit_seq; every output is packed into one
// vector and compared against hand-computed expectations.
module tb_control_unit_seq;

    logic       clk;
    logic       rst_n;
    logic       instr_valid;
    logic [5:0] opcode;
    logic       stall;
    logic       flush;
    logic [3:0] exec_cmd;
    logic       mem_r_en, mem_w_en, wb_en, is_imm, single_src;
    logic [1:0] branch_type;
    logic [2:0] uop_sel;
    logic       freeze, busy, illegal_op;

    int unsigned vec_cnt = 0;
    int unsigned err_cnt = 0;

    localparam logic [5:0] NOP  = 6'b000000;
    localparam logic [5:0] ADD  = 6'b000001;
    localparam logic [5:0] SUB  = 6'b000011;
    localparam logic [5:0] NOR  = 6'b000111;
    localparam logic [5:0] XOR  = 6'b001000;
    localparam logic [5:0] SLL  = 6'b001010;
    localparam logic [5:0] SRL  = 6'b001100;
    localparam logic [5:0] SUBI = 6'b100001;
    localparam logic [5:0] LD   = 6'b100100;
    localparam logic [5:0] ST   = 6'b100101;
    localparam logic [5:0] BEZ  = 6'b101000;
    localparam logic [5:0] BNE  = 6'b101001;
    localparam logic [5:0] JMP  = 6'b101010;
    localparam logic [5:0] ROT  = 6'b111110;
    localparam logic [5:0] SWP  = 6'b111111;
    localparam logic [5:0] UNDF = 6'b010101;

    control_unit_seq #(
        .OPCODE_W (6),
        .CMD_W    (4),
        .MAX_UOPS (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .stall       (stall),
        .flush       (flush),
        .exec_cmd    (exec_cmd),
        .mem_r_en    (mem_r_en),
        .mem_w_en    (mem_w_en),
        .wb_en       (wb_en),
        .is_imm      (is_imm),
        .branch_type (branch_type),
        .single_src  (single_src),
        .uop_sel     (uop_sel),
        .freeze      (freeze),
        .busy        (busy),
        .illegal_op  (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [16:0] obs;
    assign obs = {exec_cmd, mem_r_en, mem_w_en, wb_en, is_imm, branch_type, single_src,
                  uop_sel, freeze, busy, illegal_op};

    function automatic logic [16:0] ev(input logic [3:0] cmd, input logic mr, input logic mw,
                                       input logic wb, input logic imm, input logic [1:0] br,
                                       input logic ss, input logic [2:0] sel, input logic frz,
                                       input logic bsy, input logic ill);
        return {cmd, mr, mw, wb, imm, br, ss, sel, frz, bsy, ill};
    endfunction

    task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %b expected %b (cmd,mr,mw,wb,imm,br,ss,sel,frz,busy,ill)",
                     tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, check mid-cycle, then advance past the next rising edge.
    task automatic cyc(input string tag, input logic v, input logic [5:0] op, input logic st,
                       input logic fl, input logic [16:0] exp);
        instr_valid = v;
        opcode      = op;
        stall       = st;
        flush       = fl;
        #2;
        check(tag, obs, exp);
        @(posedge clk);
        #1;
    endtask

    logic [16:0] ZERO, E_ADD, E_SUB, E_XOR, U_BUSY;

    initial begin
        ZERO   = '0;
        E_ADD  = ev(4'b0000, 0, 0, 1, 0, 2'b00, 0, 3'd0, 0, 0, 0);
        E_SUB  = ev(4'b0010, 0, 0, 1, 0, 2'b00, 0, 3'd0, 0, 0, 0);
        E_XOR  = ev(4'b0111, 0, 0, 1, 0, 2'b00, 0, 3'd0, 0, 0, 0);
        U_BUSY = ev(4'b0000, 0, 0, 0, 0, 2'b00, 0, 3'd0, 0, 1, 0);

        rst_n       = 1'b0;
        instr_valid = 1'b1;
        opcode      = ADD;
        stall       = 1'b0;
        flush       = 1'b0;
        #3;
        check("reset_outputs", obs, ZERO);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        cyc("add",  1, ADD,  0, 0, E_ADD);
        cyc("subi", 1, SUBI, 0, 0, ev(4'b0010, 0, 0, 1, 1, 2'b00, 1, 3'd0, 0, 0, 0));
        cyc("ld",   1, LD,   0, 0, ev(4'b0000, 1, 0, 1, 1, 2'b00, 1, 3'd0, 0, 0, 0));
        cyc("st",   1, ST,   0, 0, ev(4'b0000, 0, 1, 0, 1, 2'b00, 0, 3'd0, 0, 0, 0));
        cyc("bne",  1, BNE,  0, 0, ev(4'b0000, 0, 0, 0, 1, 2'b10, 0, 3'd0, 0, 0, 0));
        cyc("bez",  1, BEZ,  0, 0, ev(4'b0000, 0, 0, 0, 1, 2'b01, 1, 3'd0, 0, 0, 0));
        cyc("jmp",  1, JMP,  0, 0, ev(4'b0000, 0, 0, 0, 1, 2'b11, 1, 3'd0, 0, 0, 0));
        cyc("sll",  1, SLL,  0, 0, ev(4'b1000, 0, 0, 1, 0, 2'b00, 0, 3'd0, 0, 0, 0));
        cyc("srl",  1, SRL,  0, 0, ev(4'b1010, 0, 0, 1, 0, 2'b00, 0, 3'd0, 0, 0, 0));
        cyc("nor",  1, NOR,  0, 0, ev(4'b0110, 0, 0, 1, 0, 2'b00, 0, 3'd0, 0, 0, 0));
        cyc("nop",  1, NOP,  0, 0, ZERO);

        cyc("swp_u0",   1, SWP, 0, 0, ev(4'b1100, 0, 0, 1, 0, 2'b00, 0, 3'd1, 1, 0, 0));
        cyc("swp_u1",   1, ADD, 0, 0, ev(4'b1101, 0, 0, 1, 0, 2'b00, 0, 3'd2, 0, 1, 0));
        cyc("swp_next", 1, ADD, 0, 0, E_ADD);

        cyc("rot_u0",    1, ROT, 0, 0, ev(4'b1100, 0, 0, 1, 0, 2'b00, 0, 3'd1, 1, 0, 0));
        cyc("rot_stl0",  1, ROT, 1, 0, ev(4'b0000, 0, 0, 0, 0, 2'b00, 0, 3'd0, 1, 1, 0));
        cyc("rot_stl1",  1, ROT, 1, 0, ev(4'b0000, 0, 0, 0, 0, 2'b00, 0, 3'd0, 1, 1, 0));
        cyc("rot_u1",    1, ROT, 0, 0, ev(4'b1101, 0, 0, 1, 0, 2'b00, 0, 3'd2, 1, 1, 0));
        cyc("rot_u2",    1, ROT, 0, 0, ev(4'b1110, 0, 0, 1, 0, 2'b00, 0, 3'd3, 0, 1, 0));
        cyc("rot_done",  1, NOP, 0, 0, ZERO);

        cyc("idle_stall", 1, SWP, 1, 0, ZERO);
        cyc("idle_flush", 1, SWP, 0, 1, ZERO);
        cyc("after_stl",  1, ADD, 0, 0, E_ADD);

        cyc("rotf_u0",   1, ROT, 0, 0, ev(4'b1100, 0, 0, 1, 0, 2'b00, 0, 3'd1, 1, 0, 0));
        cyc("rotf_fl",   1, ROT, 0, 1, U_BUSY);
        cyc("rotf_next", 1, SUB, 0, 0, E_SUB);

        cyc("swpf_u0",   1, SWP, 0, 0, ev(4'b1100, 0, 0, 1, 0, 2'b00, 0, 3'd1, 1, 0, 0));
        cyc("swpf_both", 1, SWP, 1, 1, U_BUSY);
        cyc("swpf_next", 1, XOR, 0, 0, E_XOR);

        cyc("illegal",    1, UNDF, 0, 0, ev(4'b0000, 0, 0, 0, 0, 2'b00, 0, 3'd0, 0, 0, 1));
        cyc("illegal_nv", 0, UNDF, 0, 0, ZERO);

        cyc("b2b_swp0", 1, SWP, 0, 0, ev(4'b1100, 0, 0, 1, 0, 2'b00, 0, 3'd1, 1, 0, 0));
        cyc("b2b_swp1", 1, ROT, 0, 0, ev(4'b1101, 0, 0, 1, 0, 2'b00, 0, 3'd2, 0, 1, 0));
        cyc("b2b_rot0", 1, ROT, 0, 0, ev(4'b1100, 0, 0, 1, 0, 2'b00, 0, 3'd1, 1, 0, 0));
        cyc("b2b_rot1", 1, ADD, 0, 0, ev(4'b1101, 0, 0, 1, 0, 2'b00, 0, 3'd2, 1, 1, 0));
        cyc("b2b_rot2", 1, ADD, 0, 0, ev(4'b1110, 0, 0, 1, 0, 2'b00, 0, 3'd3, 0, 1, 0));
        cyc("b2b_nv",   0, ADD, 0, 0, ZERO);

        // Asynchronous reset in the middle of SWP uop0, then restart from uop0.
        instr_valid = 1'b1;
        opcode      = SWP;
        stall       = 1'b0;
        flush       = 1'b0;
        #2;
        check("rst_pre_u0", obs, ev(4'b1100, 0, 0, 1, 0, 2'b00, 0, 3'd1, 1, 0, 0));
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_async", obs, ZERO);
        @(posedge clk);
        #1;
        check("rst_held", obs, ZERO);
        rst_n = 1'b1;
        #2;
        check("rst_restart_u0", obs, ev(4'b1100, 0, 0, 1, 0, 2'b00, 0, 3'd1, 1, 0, 0));
        @(posedge clk);
        #1;
        cyc("rst_restart_u1", 1, ADD, 0, 0, ev(4'b1101, 0, 0, 1, 0, 2'b00, 0, 3'd2, 0, 1, 0));
        cyc("rst_after", 1, ADD, 0, 0, E_ADD);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
